// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller: Moore FSM sequencing fetch/decode/execute,
// plus ALU and immediate-format decoders for the shared datapath.
module multicycle_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_is_lw, w_is_sw, w_is_r, w_is_i, w_is_beq, w_is_jal, w_supported;
  logic       w_pcupdate, w_branch, w_irwrite, w_regwrite, w_memwrite, w_adrsrc;
  logic [1:0] w_resultsrc, w_alusrca, w_alusrcb, w_aluop;

  assign w_is_lw     = (op == OP_LW);
  assign w_is_sw     = (op == OP_SW);
  assign w_is_r      = (op == OP_R);
  assign w_is_i      = (op == OP_I);
  assign w_is_beq    = (op == OP_BEQ);
  assign w_is_jal    = (op == OP_JAL);
  assign w_supported = w_is_lw | w_is_sw | w_is_r | w_is_i | w_is_beq | w_is_jal;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_lw || w_is_sw) w_next = S_MEMADR;
        else if (w_is_r)        w_next = S_EXECUTER;
        else if (w_is_i)        w_next = S_EXECUTEI;
        else if (w_is_beq)      w_next = S_BEQ;
        else if (w_is_jal)      w_next = S_JAL;
        else                    w_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
      end
      S_MEMADR: begin
        if (w_is_lw)      w_next = S_MEMREAD;
        else if (w_is_sw) w_next = S_MEMWRITE;
        else              w_next = S_FETCH;
      end
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // Moore decode; unused encodings 12-15 fall to the all-zero default.
  always_comb begin
    w_pcupdate  = 1'b0;
    w_branch    = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    w_adrsrc    = 1'b0;
    w_resultsrc = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_aluop     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_pcupdate  = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      S_DECODE: begin
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
      end
      S_MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
      end
      S_MEMREAD: w_adrsrc = 1'b1;
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        w_alusrca = 2'b10;
        w_aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BEQ: begin
        w_alusrca = 2'b10;
        w_aluop   = ALUOP_SUB;
        w_branch  = 1'b1;
      end
      S_JAL: begin
        w_alusrca  = 2'b01;
        w_alusrcb  = 2'b10;
        w_pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (w_aluop)
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    if (w_is_sw)       ImmSrc = 2'b01;
    else if (w_is_beq) ImmSrc = 2'b10;
    else if (w_is_jal) ImmSrc = 2'b11;
  end

  // Write enables are suppressed during reset so nothing commits while the FSM reloads.
  assign PCWrite   = ~reset & (w_pcupdate | (w_branch & zero));
  assign IRWrite   = ~reset & w_irwrite;
  assign RegWrite  = ~reset & w_regwrite;
  assign MemWrite  = ~reset & w_memwrite;
  assign illegal   = ~reset & (r_state == S_DECODE) & ~w_supported;
  assign AdrSrc    = w_adrsrc;
  assign ResultSrc = w_resultsrc;
  assign ALUSrcA   = w_alusrca;
  assign ALUSrcB   = w_alusrcb;
  assign state     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; two instances cover both ILLEGAL_TRAP settings.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset0, reset1;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, zero;

  logic pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic [3:0] st0;
  logic pcw1, adr1, mw1, irw1, rw1, ill1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;
  logic [3:0] st1;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .RegWrite(rw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ImmSrc(imm0), .ALUControl(alu0),
    .state(st0), .illegal(ill0));

  multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset1), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1),
    .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ImmSrc(imm1), .ALUControl(alu1),
    .state(st1), .illegal(ill1));

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    step(); step();
    check("rst_state0", {4'd0, st0}, 8'd0);
    check("rst_state1", {4'd0, st1}, 8'd0);
    check("rst_irwrite", {7'd0, irw0}, 8'd0);
    check("rst_pcwrite", {7'd0, pcw0}, 8'd0);
    check("rst_regwrite", {7'd0, rw0}, 8'd0);

    reset0 = 1'b0; #1;
    check("first_fetch_irwrite", {7'd0, irw0}, 8'd1);
    check("first_fetch_pcwrite", {7'd0, pcw0}, 8'd1);
    check("fetch_resultsrc", {6'd0, rs0}, 8'd2);
    check("fetch_alusrcb", {6'd0, sb0}, 8'd2);

    // lw
    step(); check("lw_s1", {4'd0, st0}, 8'd1);
    check("decode_alusrca", {6'd0, sa0}, 8'd1);
    check("decode_alusrcb", {6'd0, sb0}, 8'd1);
    step(); check("lw_s2", {4'd0, st0}, 8'd2);
    check("lw_imm", {6'd0, imm0}, 8'd0);
    check("lw_memadr_srca", {6'd0, sa0}, 8'd2);
    step(); check("lw_s3", {4'd0, st0}, 8'd3);
    check("lw_s3_adrsrc", {7'd0, adr0}, 8'd1);
    check("lw_s3_regwrite", {7'd0, rw0}, 8'd0);
    step(); check("lw_s4", {4'd0, st0}, 8'd4);
    check("lw_s4_regwrite", {7'd0, rw0}, 8'd1);
    check("lw_s4_resultsrc", {6'd0, rs0}, 8'd1);
    step(); check("lw_end", {4'd0, st0}, 8'd0);
    check("lw_end_regwrite", {7'd0, rw0}, 8'd0);

    // sw
    op = 7'b0100011; #1;
    check("sw_imm", {6'd0, imm0}, 8'd1);
    step(); check("sw_s1", {4'd0, st0}, 8'd1);
    check("sw_s1_memwrite", {7'd0, mw0}, 8'd0);
    step(); check("sw_s2", {4'd0, st0}, 8'd2);
    step(); check("sw_s5", {4'd0, st0}, 8'd5);
    check("sw_s5_memwrite", {7'd0, mw0}, 8'd1);
    check("sw_s5_adrsrc", {7'd0, adr0}, 8'd1);
    step(); check("sw_end", {4'd0, st0}, 8'd0);

    // R-type, varying funct fields while parked in EXECUTER
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); check("r_s1", {4'd0, st0}, 8'd1);
    step(); check("r_s6", {4'd0, st0}, 8'd6);
    check("r_sub", {5'd0, alu0}, 8'd1);
    check("r_srca", {6'd0, sa0}, 8'd2);
    check("r_srcb", {6'd0, sb0}, 8'd0);
    funct7b5 = 1'b0; #1; check("r_add", {5'd0, alu0}, 8'd0);
    funct3 = 3'b010; #1; check("r_slt", {5'd0, alu0}, 8'd5);
    funct3 = 3'b110; #1; check("r_or", {5'd0, alu0}, 8'd3);
    funct3 = 3'b111; #1; check("r_and", {5'd0, alu0}, 8'd2);
    step(); check("r_s8", {4'd0, st0}, 8'd8);
    check("r_s8_regwrite", {7'd0, rw0}, 8'd1);
    step(); check("r_end", {4'd0, st0}, 8'd0);

    // I-ALU: funct7b5 must not turn addi into sub
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); step(); check("i_s7", {4'd0, st0}, 8'd7);
    check("i_addi", {5'd0, alu0}, 8'd0);
    check("i_srcb", {6'd0, sb0}, 8'd1);
    step(); check("i_s8", {4'd0, st0}, 8'd8);
    step(); check("i_end", {4'd0, st0}, 8'd0);

    // beq, both zero values
    op = 7'b1100011; zero = 1'b1; funct7b5 = 1'b0; #1;
    check("beq_imm", {6'd0, imm0}, 8'd2);
    step(); step(); check("beq_s9", {4'd0, st0}, 8'd9);
    check("beq_taken_pcwrite", {7'd0, pcw0}, 8'd1);
    check("beq_aluctl", {5'd0, alu0}, 8'd1);
    zero = 1'b0; #1;
    check("beq_not_taken_pcwrite", {7'd0, pcw0}, 8'd0);
    step(); check("beq_end", {4'd0, st0}, 8'd0);

    // jal
    op = 7'b1101111; #1;
    check("jal_imm", {6'd0, imm0}, 8'd3);
    step(); step(); check("jal_s10", {4'd0, st0}, 8'd10);
    check("jal_pcwrite", {7'd0, pcw0}, 8'd1);
    check("jal_resultsrc", {6'd0, rs0}, 8'd0);
    step(); check("jal_s8", {4'd0, st0}, 8'd8);
    step(); check("jal_end", {4'd0, st0}, 8'd0);

    // unsupported opcode, no trap
    op = 7'b1111111; #1;
    check("bad_imm", {6'd0, imm0}, 8'd0);
    check("bad_fetch_illegal", {7'd0, ill0}, 8'd0);
    step(); check("bad_s1", {4'd0, st0}, 8'd1);
    check("bad_illegal", {7'd0, ill0}, 8'd1);
    step(); check("bad_back_fetch", {4'd0, st0}, 8'd0);
    check("bad_illegal_clear", {7'd0, ill0}, 8'd0);

    // unsupported opcode with trap: HALT held until reset
    reset1 = 1'b0;
    step(); check("trap_s1", {4'd0, st1}, 8'd1);
    check("trap_illegal", {7'd0, ill1}, 8'd1);
    step();
    for (int i = 0; i < 20; i++) begin
      check("trap_halt_state", {4'd0, st1}, 8'd11);
      check("trap_halt_pcwrite", {7'd0, pcw1}, 8'd0);
      step();
    end
    check("trap_illegal_halt", {7'd0, ill1}, 8'd0);
    reset1 = 1'b1;
    step(); check("trap_reset_state", {4'd0, st1}, 8'd0);

    // reset mid-lw in MEMREAD
    reset0 = 1'b1; step(); reset0 = 1'b0;
    op = 7'b0000011; #1;
    check("mid_start", {4'd0, st0}, 8'd0);
    step(); step(); step();
    check("mid_s3", {4'd0, st0}, 8'd3);
    reset0 = 1'b1; #1;
    check("mid_rst_regwrite", {7'd0, rw0}, 8'd0);
    check("mid_rst_memwrite", {7'd0, mw0}, 8'd0);
    step(); check("mid_rst_state", {4'd0, st0}, 8'd0);
    check("mid_rst_irwrite", {7'd0, irw0}, 8'd0);
    check("mid_rst_regwrite2", {7'd0, rw0}, 8'd0);
    check("mid_rst_memwrite2", {7'd0, mw0}, 8'd0);
    reset0 = 1'b0; #1;
    check("mid_release_irwrite", {7'd0, irw0}, 8'd1);
    step(); check("mid_release_decode", {4'd0, st0}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: ILLEGAL_TRAP, default 0, 1 = unsupported opcode parks the FSM in HALT, 0 = unsupported opcode returns to FETCH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  opcode from instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-009 ResultSrc  output  2  00 ALUOut, 01 read data, 10 ALUResult.
REQ-010 ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1.
REQ-011 ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4.
REQ-012 ImmSrc  output  2  00 I, 01 S, 10 B, 11 J.
REQ-013 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-014 state  output  4  current FSM state (debug).
REQ-015 illegal  output  1  unsupported opcode detected in DECODE.

Function
REQ-016 States/encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11; 12-15 SHALL go to FETCH next cycle with all enables 0.
REQ-017 Supported opcodes SHALL be: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-018 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I-ALU), BEQ, JAL; other opcode -> HALT if ILLEGAL_TRAP=1, else FETCH.
REQ-019 Transitions: MEMADR->MEMREAD (lw) / MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH; HALT->HALT until reset.
REQ-020 Instruction latency in cycles SHALL be: lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3.
REQ-021 Outputs SHALL be Moore-decoded from state (except PCWrite, ALUControl, ImmSrc, illegal); unlisted signals 0.
REQ-022 FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp add, ResultSrc 10, PCUpdate 1.
REQ-023 DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp add. MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp add.
REQ-024 MEMREAD: ResultSrc 00, AdrSrc 1. MEMWB: ResultSrc 01, RegWrite 1. MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
REQ-025 EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp funct. EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp funct. ALUWB: ResultSrc 00, RegWrite 1.
REQ-026 BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp sub, ResultSrc 00, Branch 1. JAL: ALUSrcA 01, ALUSrcB 10, ALUOp add, ResultSrc 00, PCUpdate 1. HALT: all enables 0.
REQ-027 PCWrite SHALL equal PCUpdate OR (Branch AND zero), combinational in zero.
REQ-028 ALU decode: ALUOp add->000, sub->001; funct: funct3 000 -> 001 if op[5] AND funct7b5 else 000; 010->101; 110->011; 111->010; other funct3 ->000.
REQ-029 ImmSrc SHALL be decoded from op in every state per REQ-012; unsupported op -> 00.
REQ-030 illegal SHALL be 1 only in DECODE with unsupported op, for exactly one cycle.

Reset
REQ-031 reset high at a clock edge SHALL load FETCH, from any state including HALT and mid-instruction.
REQ-032 While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and illegal SHALL be forced 0.
REQ-033 First rising edge with reset low SHALL execute FETCH (IRWrite 1, PCWrite 1).

Verification
REQ-034 lw (op 0000011): state sequence 0,1,2,3,4,0; RegWrite 1 only in state 4; ResultSrc 01 there.
REQ-035 sw (op 0100011): sequence 0,1,2,5,0; MemWrite 1 only in state 5 with AdrSrc 1; ImmSrc 01.
REQ-036 R sub (funct3 000, funct7b5 1): ALUControl 001 in state 6; R add (funct7b5 0): 000; funct3 010: 101.
REQ-037 beq with zero=1 -> PCWrite 1 in state 9; zero=0 -> PCWrite 0; both return to state 0.
REQ-038 op 1111111: ILLEGAL_TRAP=0 -> illegal 1 in state 1 then state 0; ILLEGAL_TRAP=1 -> state 11 held 20 cycles, reset -> state 0.
REQ-039 reset asserted in state 3 -> state 0 next edge, MemWrite/RegWrite 0 throughout reset.
